// File: rtl/bsg_manycore_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bsg_manycore_reset_seq_pkg
// Purpose : Shared types for the manycore reset sequencer.
//           - seq_state_e            : sequencer FSM encoding
//           - BSG_MANYCORE_STAT_ENTRY_S : macro declaring the {tag, ctr}
//                                      stat record for given widths
//           - safe_clog2             : clog2 that never returns 0
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================

// Declares a packed stat record type named stat_entry_s inside the calling
// scope, so that each instance can size it from its own parameters.
`define BSG_MANYCORE_STAT_ENTRY_S(tag_w, ctr_w) \
  typedef struct packed { \
    logic [(tag_w)-1:0] tag; \
    logic [(ctr_w)-1:0] ctr; \
  } stat_entry_s

package bsg_manycore_reset_seq_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_stage = 2'd1,
    e_run   = 2'd2,
    e_done  = 2'd3
  } seq_state_e;

  // Counter/pointer width for a modulus of n; at least one bit so that
  // single-entry configurations still get a legal vector.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module  : bsg_fifo_1r1w_small
// Purpose : Small circular-buffer FIFO, one write and one read port,
//           valid-then-yumi output handshake.
// Ports   : clk_i, reset_i (async, active-high)
//           v_i / data_i     write strobe and data
//           ready_o          not full (a write while full is accepted only
//                            when yumi_i pops the head in the same cycle)
//           v_o / data_o     head valid and head data
//           yumi_i           pop the head (only legal while v_o is high)
// Rev     : 1.0  initial release
// ============================================================================
module bsg_fifo_1r1w_small
  import bsg_manycore_reset_seq_pkg::*;
#(
  parameter int width_p = 64,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int c_ptr_w = safe_clog2(els_p);
  localparam int c_cnt_w = $clog2(els_p + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(els_p - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(els_p);

  logic [width_p-1:0] r_mem [els_p];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_full, w_empty, w_wr, w_rd;

  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);
  // A write into a full FIFO is legal when the head leaves in the same
  // cycle; the write then lands in the slot being vacated.
  assign w_wr    = v_i & (~w_full | yumi_i);
  assign w_rd    = yumi_i & ~w_empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < els_p; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      if (w_wr && !w_rd)      r_count <= r_count + c_cnt_w'(1);
      else if (w_rd && !w_wr) r_count <= r_count - c_cnt_w'(1);
    end
  end

  assign ready_o = ~w_full;
  assign v_o     = ~w_empty;
  assign data_o  = r_mem[r_rd_ptr];

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && w_empty))
        else $error("bsg_fifo_1r1w_small: yumi_i asserted while empty");
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : bsg_manycore_reset_sequencer
// Purpose : Holds num_domains_p reset outputs until tag programming is done,
//           releases them one by one every stage_gap_p cycles, then runs a
//           saturating cycle counter and buffers counter-stamped print-stat
//           events in a small FIFO.
// Ports   : clk_i, reset_i (async, active-high)
//           tag_done_i        tag programming complete (sticky once seen)
//           finish_v_i        stop the counter, enter DONE
//           print_stat_v_i / print_stat_tag_i   stat event push
//           reset_o           per-domain reset, active-high
//           all_released_o    every domain out of reset
//           ctr_o             global cycle counter
//           stat_v_o / stat_tag_o / stat_ctr_o / stat_yumi_i  FIFO head
//           stat_drop_o       sticky: push lost on a full FIFO
//           timeout_o         sticky watchdog flag
// Config  : BSG_RESET_SEQ_WATCHDOG_EN enables the RUN-state watchdog;
//           without it timeout_o is tied low and timeout_p is unused.
// Rev     : 1.0  initial release
// ============================================================================
module bsg_manycore_reset_sequencer
  import bsg_manycore_reset_seq_pkg::*;
#(
  parameter int num_domains_p = 3,
  parameter int stage_gap_p   = 3,
  parameter int ctr_width_p   = 32,
  parameter int data_width_p  = 32,
  parameter int stat_els_p    = 4,
  parameter int timeout_p     = 2**20
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     tag_done_i,
  input  logic                     finish_v_i,
  input  logic                     print_stat_v_i,
  input  logic [data_width_p-1:0]  print_stat_tag_i,
  output logic [num_domains_p-1:0] reset_o,
  output logic                     all_released_o,
  output logic [ctr_width_p-1:0]   ctr_o,
  output logic                     stat_v_o,
  output logic [data_width_p-1:0]  stat_tag_o,
  output logic [ctr_width_p-1:0]   stat_ctr_o,
  input  logic                     stat_yumi_i,
  output logic                     stat_drop_o,
  output logic                     timeout_o
);

  localparam int c_idx_w = safe_clog2(num_domains_p);
  localparam int c_gap_w = safe_clog2(stage_gap_p);
  localparam logic [c_idx_w-1:0]     c_idx_last = c_idx_w'(num_domains_p - 1);
  localparam logic [c_gap_w-1:0]     c_gap_last = c_gap_w'(stage_gap_p - 1);
  localparam logic [ctr_width_p-1:0] c_ctr_max  = '1;

  `BSG_MANYCORE_STAT_ENTRY_S(data_width_p, ctr_width_p);

  seq_state_e               r_state, w_state_next;
  logic [c_idx_w-1:0]       r_idx;
  logic [c_gap_w-1:0]       r_gap;
  logic [num_domains_p-1:0] r_reset;
  logic                     r_all_released;
  logic [ctr_width_p-1:0]   r_ctr;
  logic                     r_drop;

  logic        w_release, w_last_release, w_timeout_hit, w_ctr_en;
  logic        w_push, w_push_accept, w_push_drop;
  logic        w_fifo_ready, w_fifo_v;
  stat_entry_s w_push_entry, w_head_entry;

`ifdef BSG_RESET_SEQ_WATCHDOG_EN
  // Finish in the same cycle takes priority over the watchdog.
  assign w_timeout_hit = (r_state == e_run) & ~finish_v_i
                       & (r_ctr == ctr_width_p'(timeout_p - 1));
`else
  assign w_timeout_hit = 1'b0;
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (timeout_p != 0);
`endif

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= e_idle;
    else         r_state <= w_state_next;
  end

  // Next-state logic; tag_done_i only matters in IDLE, which makes it sticky.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      e_idle:  if (tag_done_i)                   w_state_next = e_stage;
      e_stage: if (w_last_release)               w_state_next = e_run;
      e_run:   if (finish_v_i || w_timeout_hit)  w_state_next = e_done;
      default: w_state_next = r_state;
    endcase
  end

  // Output/datapath control
  always_comb begin
    w_release      = (r_state == e_stage) && (r_gap == c_gap_last);
    w_last_release = w_release && (r_idx == c_idx_last);
    // Counter advances only while RUN persists past this edge.
    w_ctr_en       = (r_state == e_run) && (w_state_next == e_run)
                     && (r_ctr != c_ctr_max);
    w_push         = print_stat_v_i && ((r_state == e_run) || (r_state == e_done));
    w_push_accept  = w_push && (w_fifo_ready || stat_yumi_i);
    w_push_drop    = w_push && !w_fifo_ready && !stat_yumi_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_idx          <= '0;
      r_gap          <= '0;
      r_all_released <= 1'b0;
      r_ctr          <= '0;
      r_drop         <= 1'b0;
    end else begin
      if (r_state == e_stage) begin
        if (w_release) begin
          r_gap <= '0;
          r_idx <= r_idx + c_idx_w'(1);
        end else begin
          r_gap <= r_gap + c_gap_w'(1);
        end
      end
      if (w_last_release) r_all_released <= 1'b1;
      if (w_ctr_en)       r_ctr          <= r_ctr + ctr_width_p'(1);
      if (w_push_drop)    r_drop         <= 1'b1;
    end
  end

  for (genvar i = 0; i < num_domains_p; i++) begin : g_domain
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                                      r_reset[i] <= 1'b1;
      else if (w_release && (r_idx == c_idx_w'(i)))     r_reset[i] <= 1'b0;
    end
  end

`ifdef BSG_RESET_SEQ_WATCHDOG_EN
  logic r_timeout;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)            r_timeout <= 1'b0;
    else if (w_timeout_hit) r_timeout <= 1'b1;
  end
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign w_push_entry.tag = print_stat_tag_i;
  assign w_push_entry.ctr = r_ctr;

  bsg_fifo_1r1w_small #(
    .width_p (data_width_p + ctr_width_p),
    .els_p   (stat_els_p)
  ) stat_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_push_accept),
    .ready_o (w_fifo_ready),
    .data_i  (w_push_entry),
    .v_o     (w_fifo_v),
    .data_o  (w_head_entry),
    .yumi_i  (stat_yumi_i)
  );

  assign reset_o        = r_reset;
  assign all_released_o = r_all_released;
  assign ctr_o          = r_ctr;
  assign stat_drop_o    = r_drop;
  assign stat_v_o       = w_fifo_v;
  assign stat_tag_o     = w_head_entry.tag;
  assign stat_ctr_o     = w_head_entry.ctr;

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsg_manycore_reset_sequencer
// Purpose : Directed self-checking bench for bsg_manycore_reset_sequencer
//           (3 domains, gap 3, 4-entry stat FIFO, watchdog limit 50).
// Rev     : 1.0  initial release
// ============================================================================
module tb_bsg_manycore_reset_sequencer;

  localparam int c_nd  = 3;
  localparam int c_gap = 3;
  localparam int c_cw  = 32;
  localparam int c_dw  = 32;
  localparam int c_els = 4;
  localparam int c_to  = 50;

  logic              clk = 1'b0;
  logic              reset_i, tag_done_i, finish_v_i, print_stat_v_i, stat_yumi_i;
  logic [c_dw-1:0]   print_stat_tag_i;
  logic [c_nd-1:0]   reset_o;
  logic              all_released_o, stat_v_o, stat_drop_o, timeout_o;
  logic [c_cw-1:0]   ctr_o, stat_ctr_o;
  logic [c_dw-1:0]   stat_tag_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bsg_manycore_reset_sequencer #(
    .num_domains_p (c_nd),
    .stage_gap_p   (c_gap),
    .ctr_width_p   (c_cw),
    .data_width_p  (c_dw),
    .stat_els_p    (c_els),
    .timeout_p     (c_to)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .tag_done_i       (tag_done_i),
    .finish_v_i       (finish_v_i),
    .print_stat_v_i   (print_stat_v_i),
    .print_stat_tag_i (print_stat_tag_i),
    .reset_o          (reset_o),
    .all_released_o   (all_released_o),
    .ctr_o            (ctr_o),
    .stat_v_o         (stat_v_o),
    .stat_tag_o       (stat_tag_o),
    .stat_ctr_o       (stat_ctr_o),
    .stat_yumi_i      (stat_yumi_i),
    .stat_drop_o      (stat_drop_o),
    .timeout_o        (timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives tag_done_i so edge k samples it; checks the release schedule.
  // With pulse set, tag_done_i drops after edge k and a stat push is
  // attempted during STAGE, which must be ignored.
  task automatic run_sequence(input bit pulse);
    tag_done_i = 1'b1;
    tick();                                   // edge k
    if (pulse) tag_done_i = 1'b0;
    check("stage_k", reset_o, 3'b111);
    print_stat_v_i   = pulse;
    print_stat_tag_i = 32'h77;
    tick();                                   // k+1
    print_stat_v_i = 1'b0;
    tick();                                   // k+2
    check("stage_k2", reset_o, 3'b111);
    tick();                                   // k+3
    check("rel_d0", reset_o, 3'b110);
    tick_n(2);                                // k+5
    check("hold_d0", reset_o, 3'b110);
    tick();                                   // k+6
    check("rel_d1", reset_o, 3'b100);
    tick_n(2);                                // k+8
    check("not_all", all_released_o, 1'b0);
    tick();                                   // k+9
    check("rel_d2", reset_o, 3'b000);
    check("all_rel", all_released_o, 1'b1);
    check("ctr_first", ctr_o, 0);
    check("stage_push_ignored", stat_v_o, 1'b0);
    tick();
    check("ctr_second", ctr_o, 1);
  endtask

  initial begin
    int n;
    reset_i = 1'b1; tag_done_i = 1'b0; finish_v_i = 1'b0;
    print_stat_v_i = 1'b0; print_stat_tag_i = '0; stat_yumi_i = 1'b0;
    tick_n(2);
    check("rst_reset_o", reset_o, 3'b111);
    check("rst_all_rel", all_released_o, 1'b0);
    check("rst_ctr", ctr_o, 0);
    check("rst_stat_v", stat_v_o, 1'b0);
    check("rst_stat_tag", stat_tag_o, 0);
    check("rst_stat_ctr", stat_ctr_o, 0);
    check("rst_drop", stat_drop_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    reset_i = 1'b0;
    tick_n(3);
    check("idle_hold", reset_o, 3'b111);

    // Held tag_done_i
    run_sequence(1'b0);
    tag_done_i = 1'b0;

    // Fill FIFO with A..D at ctr stamps 1..4
    for (int i = 0; i < 4; i++) begin
      print_stat_v_i = 1'b1; print_stat_tag_i = 32'hA + i;
      tick();
    end
    print_stat_v_i = 1'b0;
    check("full_no_drop", stat_drop_o, 1'b0);
    check("head_v", stat_v_o, 1'b1);
    check("head_a_tag", stat_tag_o, 32'hA);
    check("head_a_ctr", stat_ctr_o, 1);
    // E pushed while full with a simultaneous pop: accepted
    print_stat_v_i = 1'b1; print_stat_tag_i = 32'hE; stat_yumi_i = 1'b1;
    tick();
    stat_yumi_i = 1'b0;
    check("push_pop_no_drop", stat_drop_o, 1'b0);
    // F pushed while full without a pop: lost
    print_stat_tag_i = 32'hF;
    tick();
    print_stat_v_i = 1'b0;
    check("drop_set", stat_drop_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("drain_tag", stat_tag_o, 32'hB + i);
      check("drain_ctr", stat_ctr_o, 2 + i);
      stat_yumi_i = 1'b1;
      tick();
      stat_yumi_i = 1'b0;
    end
    check("drained", stat_v_o, 1'b0);

    // Finish at ctr 100
    n = 0;
    while (ctr_o != 100 && n < 200) begin tick(); n++; end
    check("reach_100", ctr_o, 100);
    finish_v_i = 1'b1;
    tick();
    finish_v_i = 1'b0;
    tick_n(5);
    check("ctr_frozen", ctr_o, 100);
    print_stat_v_i = 1'b1; print_stat_tag_i = 32'h55;
    tick();
    print_stat_v_i = 1'b0;
    check("done_push_v", stat_v_o, 1'b1);
    check("done_push_tag", stat_tag_o, 32'h55);
    check("done_push_ctr", stat_ctr_o, 100);
    stat_yumi_i = 1'b1; tick(); stat_yumi_i = 1'b0;

    // Reset clears sticky drop and counter
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    check("rst2_drop", stat_drop_o, 1'b0);
    check("rst2_ctr", ctr_o, 0);

    // Pulsed tag_done_i
    run_sequence(1'b1);
    print_stat_v_i = 1'b1; print_stat_tag_i = 32'h33;
    tick();
    print_stat_v_i = 1'b0;
    check("run_push_v", stat_v_o, 1'b1);
    #3 reset_i = 1'b1;
    #1;
    check("async_fifo_clr", stat_v_o, 1'b0);
    check("async_ctr_clr", ctr_o, 0);
    check("async_reset_o", reset_o, 3'b111);
    tick(); reset_i = 1'b0;

    // Reset during STAGE after domain 0 released
    tag_done_i = 1'b1; tick(); tag_done_i = 1'b0;
    tick_n(3);
    check("mid_stage_d0", reset_o, 3'b110);
    #3 reset_i = 1'b1;
    #1;
    check("mid_stage_async", reset_o, 3'b111);
    check("mid_stage_all", all_released_o, 1'b0);
    check("mid_stage_fifo", stat_v_o, 1'b0);
    tick(); reset_i = 1'b0;
    tick_n(10);
    check("back_to_idle", reset_o, 3'b111);

    // Watchdog
    run_sequence(1'b0);
    tag_done_i = 1'b0;
    tick_n(59);
`ifdef BSG_RESET_SEQ_WATCHDOG_EN
    check("wd_timeout", timeout_o, 1'b1);
    check("wd_ctr", ctr_o, 49);
`else
    check("wd_timeout", timeout_o, 1'b0);
    check("wd_ctr", ctr_o, 60);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
